// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU frame-sync block: status word layout and commit FSM states.
package gpu_pkg;

    localparam int unsigned ST_IRQ      = 0;
    localparam int unsigned ST_PEND     = 1;
    localparam int unsigned ST_OVR      = 2;
    localparam int unsigned ST_VS       = 3;
    localparam int unsigned ST_LINE_LSB = 4;
    localparam int unsigned ST_LAST_LSB = 14;
    localparam int unsigned ST_FRM_LSB  = 24;
    localparam int unsigned ST_LINE_W   = 10;
    localparam int unsigned ST_FRM_W    = 8;

    typedef enum logic {
        CM_IDLE    = 1'b0,
        CM_PENDING = 1'b1
    } commit_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Normalises a sync pulse to active-high and flags the first cycle it is active.
module sync_edge_det #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic act_o,
    output logic start_o
);

    logic act_c;
    logic act_q;

    assign act_c = sync_i ^ ACTIVE_LOW;

    // Resets to the inactive level so no false edge follows reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act_c;
        end
    end

    assign start_o = act_c & ~act_q;
    assign act_o   = act_q;

endmodule

// File: rtl/gpu_frame_sync.sv
// Turns GPU v_sync/h_sync into frame/line counters, a vsync interrupt and a frame-aligned commit strobe.
module gpu_frame_sync
    import gpu_pkg::*;
#(
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter bit          HSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LINE_W           = 10,
    parameter int unsigned FRAME_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               v_sync,
    input  logic               h_sync,
    input  logic               irq_en,
    input  logic               irq_ack,
    input  logic               commit_req,
    output logic               commit_strobe,
    output logic               commit_pending,
    output logic               irq,
    output logic [FRAME_W-1:0] frame_count,
    output logic [LINE_W-1:0]  line_count,
    output logic [31:0]        status_reg
);

    logic vs_act_q;
    logic vs_start;
    logic hs_act_unused;
    logic hs_start;

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [LINE_W-1:0]  last_q, last_d;
    logic               irq_st_q, irq_st_d;
    logic               ovr_q, ovr_d;
    logic               strobe_q, strobe_d;
    commit_state_t      state_q, state_d;

    sync_edge_det #(.ACTIVE_LOW(VSYNC_ACTIVE_LOW)) u_vs_det (
        .clk     (clk),
        .reset   (reset),
        .sync_i  (v_sync),
        .act_o   (vs_act_q),
        .start_o (vs_start)
    );

    sync_edge_det #(.ACTIVE_LOW(HSYNC_ACTIVE_LOW)) u_hs_det (
        .clk     (clk),
        .reset   (reset),
        .sync_i  (h_sync),
        .act_o   (hs_act_unused),
        .start_o (hs_start)
    );

    // Counters and sticky interrupt flags; vsync beats a coincident hsync or ack.
    always_comb begin
        frame_d  = frame_q;
        line_d   = line_q;
        last_d   = last_q;
        irq_st_d = irq_st_q;
        ovr_d    = ovr_q;
        if (vs_start) begin
            frame_d = frame_q + FRAME_W'(1);
            last_d  = line_q;
            line_d  = '0;
        end else if (hs_start && (line_q != '1)) begin
            line_d = line_q + LINE_W'(1);
        end
        if (vs_start) begin
            irq_st_d = 1'b1;
        end else if (irq_ack) begin
            irq_st_d = 1'b0;
        end
        if (vs_start && irq_st_q) begin
            ovr_d = 1'b1;
        end else if (irq_ack) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q  <= '0;
            line_q   <= '0;
            last_q   <= '0;
            irq_st_q <= 1'b0;
            ovr_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            line_q   <= line_d;
            last_q   <= last_d;
            irq_st_q <= irq_st_d;
            ovr_q    <= ovr_d;
            strobe_q <= strobe_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A request landing on the vsync cycle waits a full frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CM_IDLE:    if (commit_req) state_d = CM_PENDING;
            CM_PENDING: if (vs_start)   state_d = CM_IDLE;
            default:    state_d = CM_IDLE;
        endcase
    end

    always_comb begin
        strobe_d = 1'b0;
        if ((state_q == CM_PENDING) && vs_start) begin
            strobe_d = 1'b1;
        end
    end

    always_comb begin
        status_reg                               = '0;
        status_reg[ST_IRQ]                       = irq_st_q;
        status_reg[ST_PEND]                      = (state_q == CM_PENDING);
        status_reg[ST_OVR]                       = ovr_q;
        status_reg[ST_VS]                        = vs_act_q;
        status_reg[ST_LINE_LSB +: ST_LINE_W]     = ST_LINE_W'(line_q);
        status_reg[ST_LAST_LSB +: ST_LINE_W]     = ST_LINE_W'(last_q);
        status_reg[ST_FRM_LSB +: ST_FRM_W]       = ST_FRM_W'(frame_q);
    end

    assign commit_strobe  = strobe_q;
    assign commit_pending = (state_q == CM_PENDING);
    assign irq            = irq_st_q & irq_en;
    assign frame_count    = frame_q;
    assign line_count     = line_q;

endmodule

// File: tb/tb_gpu_frame_sync.sv
// Scoreboard bench for gpu_frame_sync: stimulus queues expectations, negedge monitors compare.
module tb_gpu_frame_sync;

    localparam int unsigned LINE_W  = 10;
    localparam int unsigned FRAME_W = 32;

    localparam int S_FRAME  = 0;
    localparam int S_LINE   = 1;
    localparam int S_IRQ    = 2;
    localparam int S_ST4    = 3;
    localparam int S_LAST   = 4;
    localparam int S_STATUS = 5;
    localparam int S_PEND   = 6;
    localparam int S_STFRM  = 7;
    localparam int S_STLINE = 8;

    logic               clk        = 1'b0;
    logic               reset      = 1'b0;
    logic               v_sync     = 1'b1;
    logic               h_sync     = 1'b1;
    logic               irq_en     = 1'b0;
    logic               irq_ack    = 1'b0;
    logic               commit_req = 1'b0;
    logic               commit_strobe;
    logic               commit_pending;
    logic               irq;
    logic [FRAME_W-1:0] frame_count;
    logic [LINE_W-1:0]  line_count;
    logic [31:0]        status_reg;

    gpu_frame_sync #(
        .VSYNC_ACTIVE_LOW (1'b1),
        .HSYNC_ACTIVE_LOW (1'b1),
        .LINE_W           (LINE_W),
        .FRAME_W          (FRAME_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .v_sync         (v_sync),
        .h_sync         (h_sync),
        .irq_en         (irq_en),
        .irq_ack        (irq_ack),
        .commit_req     (commit_req),
        .commit_strobe  (commit_strobe),
        .commit_pending (commit_pending),
        .irq            (irq),
        .frame_count    (frame_count),
        .line_count     (line_count),
        .status_reg     (status_reg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb[$];
    int          strobe_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mon_act;
    int          mon_due;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_FRAME:  return frame_count;
            S_LINE:   return 32'(line_count);
            S_IRQ:    return 32'(irq);
            S_ST4:    return 32'(status_reg[3:0]);
            S_LAST:   return 32'(status_reg[23:14]);
            S_STATUS: return status_reg;
            S_PEND:   return 32'(commit_pending);
            S_STFRM:  return 32'(status_reg[31:24]);
            S_STLINE: return 32'(status_reg[13:4]);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                mon_act = sample(sb[i].sel);
                checks++;
                if (mon_act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %0h want %0h", sb[i].name, cyc, mon_act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    // Every strobe must match a queued expectation at the exact cycle.
    always @(negedge clk) begin
        if (commit_strobe === 1'b1) begin
            checks++;
            if (strobe_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc %0d got 1 want 0", cyc);
            end else begin
                mon_due = strobe_q.pop_front();
                if (mon_due != cyc) begin
                    errors++;
                    $display("FAIL strobe_cycle got %0d want %0d", cyc, mon_due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string name, input int sel, input logic [31:0] exp, input int dly);
        chk_t c;
        c.due  = cyc + dly;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic hpulse();
        h_sync = 1'b0;
        tick();
        h_sync = 1'b1;
        tick();
    endtask

    // v_sync low for four cycles; single-cycle control pulses end after the first.
    task automatic vsync(input int frame);
        v_sync = 1'b0;
        expect_at("frame", S_FRAME, 32'(frame), 1);
        expect_at("line_clr", S_LINE, 32'd0, 1);
        tick();
        irq_ack    = 1'b0;
        commit_req = 1'b0;
        repeat (3) tick();
        v_sync = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset  = 1'b1;
        irq_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (25) tick();
            expect_at("rst_frame", S_FRAME, 32'd0, 0);
            expect_at("rst_status", S_STATUS, 32'd0, 0);
            expect_at("rst_irq", S_IRQ, 32'd0, 0);
        end
        irq_en = 1'b0;

        expect_at("last", S_LAST, 32'd0, 1);
        vsync(1);
        for (int f = 2; f <= 4; f++) begin
            repeat (525) hpulse();
            expect_at("line_full", S_LINE, 32'd525, 0);
            expect_at("st_line", S_STLINE, 32'd525, 0);
            expect_at("last", S_LAST, 32'h20D, 1);
            if (f == 4) expect_at("st_frm", S_STFRM, 32'd4, 1);
            vsync(f);
        end

        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        expect_at("ack_clr", S_ST4, 32'd0, 0);
        irq_en = 1'b1;
        expect_at("irq_idle", S_IRQ, 32'd0, 0);
        tick();
        expect_at("irq_set", S_IRQ, 32'd1, 1);
        vsync(5);
        irq_ack = 1'b1;
        expect_at("irq_ack", S_IRQ, 32'd0, 1);
        tick();
        irq_ack = 1'b0;
        tick();
        irq_ack = 1'b1;
        expect_at("irq_ack_vs", S_IRQ, 32'd1, 1);
        expect_at("st_ack_vs", S_ST4, 32'b1001, 1);
        vsync(6);
        expect_at("overrun", S_ST4, 32'b1101, 1);
        vsync(7);
        irq_ack = 1'b1;
        expect_at("ovr_clr", S_ST4, 32'd0, 1);
        tick();
        irq_ack = 1'b0;
        irq_en  = 1'b0;
        expect_at("irq_masked", S_IRQ, 32'd0, 1);
        expect_at("st_masked", S_ST4, 32'b1001, 1);
        vsync(8);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();

        repeat (3) hpulse();
        commit_req = 1'b1;
        expect_at("pend_set", S_PEND, 32'd1, 1);
        tick();
        commit_req = 1'b0;
        tick();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (2) hpulse();
        strobe_q.push_back(cyc + 1);
        expect_at("pend_done", S_PEND, 32'd0, 1);
        vsync(9);
        repeat (2) hpulse();

        commit_req = 1'b1;
        expect_at("pend_vs", S_PEND, 32'd1, 1);
        vsync(10);
        repeat (2) hpulse();
        expect_at("pend_hold", S_PEND, 32'd1, 0);
        strobe_q.push_back(cyc + 1);
        expect_at("pend_done2", S_PEND, 32'd0, 1);
        vsync(11);

        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        expect_at("pend_pre_rst", S_PEND, 32'd1, 0);
        tick();
        reset = 1'b0;
        expect_at("mid_rst_status", S_STATUS, 32'd0, 0);
        expect_at("mid_rst_frame", S_FRAME, 32'd0, 0);
        expect_at("mid_rst_pend", S_PEND, 32'd0, 0);
        expect_at("mid_rst_line", S_LINE, 32'd0, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        vsync(1);
        repeat (3) hpulse();
        expect_at("last_after_rst", S_LAST, 32'd3, 1);
        vsync(2);
        expect_at("frame_after_rst", S_FRAME, 32'd2, 0);

        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
        checks++;
        if (strobe_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe got %0d want 0", strobe_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
